// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared widths, types and operation encoding for modport_mem.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Operation decoded from the {enable, read} strobe pair
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    // enable gates everything; read selects between read and copy-write
    function automatic op_e decode_op(input logic i_enable, input logic i_read);
        if (!i_enable) begin
            return OP_IDLE;
        end else if (i_read) begin
            return OP_READ;
        end else begin
            return OP_WRITE;
        end
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : DEPTH x DATA_W register array. Synchronous reset loads an
//                identity pattern (word i holds i); one write port and one
//                combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter int DEPTH    = 2**ADDR_W_P
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [ADDR_W_P-1:0] i_waddr,
    input  logic [DATA_W_P-1:0] i_wdata,
    input  logic [ADDR_W_P-1:0] i_raddr,
    output logic [DATA_W_P-1:0] o_rdata
);

    logic [DATA_W_P-1:0] r_mem [DEPTH];

    // One register per word so each word can reset to its own index
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_word
            localparam logic [DATA_W_P-1:0] c_init = DATA_W_P'(g);

            // Reset to identity value, otherwise capture on an address match
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[g] <= c_init;
                end else if (i_we && (i_waddr == ADDR_W_P'(g))) begin
                    r_mem[g] <= i_wdata;
                end
            end
        end
    endgenerate

    assign o_rdata = r_mem[i_raddr];

endmodule : mem_array
`default_nettype wire

// File: rtl/modport_mem.sv
`default_nettype none
// ============================================================================
//  Module      : modport_mem
//  Description : Single-port byte memory, device side of the intf.dut
//                modport. Reads land in the data register one cycle later;
//                writes copy the current data register into the addressed
//                word (there is no separate write-data bus).
//  Revision    : 1.0 - initial release
// ============================================================================
module modport_mem
    import mem_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter int DEPTH    = 2**ADDR_W_P
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read,
    input  logic                enable,
    input  logic [ADDR_W_P-1:0] addr,
    output logic [DATA_W_P-1:0] data
);

    op_e                 w_op;
    logic                w_we;
    logic [DATA_W_P-1:0] w_rdata;
    logic [DATA_W_P-1:0] r_data;

    assign w_op = decode_op(enable, read);
    // Reset overrides any strobe so an in-flight write is dropped
    assign w_we = (w_op == OP_WRITE) && !reset;

    // The write source is the data register as it stood before this edge
    mem_array #(
        .ADDR_W_P (ADDR_W_P),
        .DATA_W_P (DATA_W_P),
        .DEPTH    (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_we),
        .i_waddr (addr),
        .i_wdata (r_data),
        .i_raddr (addr),
        .o_rdata (w_rdata)
    );

    // Data register: cleared on reset, loaded on reads, held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_op == OP_READ) begin
            r_data <= w_rdata;
        end
    end

    assign data = r_data;

endmodule : modport_mem
`default_nettype wire

// File: tb/tb_modport_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modport_mem
//  Description : Self-checking bench for modport_mem: directed scenarios plus
//                randomized traffic against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_mem;

    logic       clk;
    logic       reset;
    logic       read;
    logic       enable;
    logic [7:0] addr;
    logic [7:0] data;

    int n_checks;
    int n_errors;

    // Reference model: plain array plus the last value presented on data
    logic [7:0] m_mem [256];
    logic [7:0] m_data;
    bit         m_armed;

    modport_mem u_dut (
        .clk    (clk),
        .reset  (reset),
        .read   (read),
        .enable (enable),
        .addr   (addr),
        .data   (data)
    );

    // 20-unit clock: posedges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Entered at posedge+2. Drives one operation, samples data 10 units
    // before the edge (result of everything up to the previous edge), then
    // lets the edge happen and advances the model. ce/cv add a directed
    // check of that sample against a known constant.
    task automatic cycle(input bit rst, input bit en, input bit rd, input logic [7:0] a,
                         input bit ce = 1'b0, input logic [7:0] cv = 8'h00,
                         input string tag = "dir");
        reset  = rst;
        enable = en;
        read   = rd;
        addr   = a;
        @(negedge clk);
        if (m_armed) chk("model", data, m_data);
        if (ce) chk(tag, data, cv);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 8'(i);
            m_data  = 8'h00;
            m_armed = 1'b1;
        end else if (en && rd) begin
            m_data = m_mem[a];
        end else if (en && !rd) begin
            m_mem[a] = m_data;
        end
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_armed  = 1'b0;
        m_data   = 8'h00;
        reset = 1'b0; read = 1'b0; enable = 1'b0; addr = 8'h00;
        @(posedge clk);
        #2;

        // Reset for two cycles, then identity reads
        cycle(1, 0, 0, 8'h00);
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 1, 8'h05, 1, 8'h00, "reset_data_zero");
        cycle(0, 1, 1, 8'hFF, 1, 8'h05, "reset_id_05");
        cycle(0, 0, 0, 8'h00, 1, 8'hFF, "reset_id_ff");

        // Copy semantics and no neighbour spill
        cycle(0, 1, 1, 8'h10);
        cycle(0, 1, 0, 8'h80, 1, 8'h10, "copy_src");
        cycle(0, 1, 1, 8'h80);
        cycle(0, 1, 1, 8'h81, 1, 8'h10, "copy_dst");
        cycle(0, 0, 0, 8'h00, 1, 8'h81, "copy_neighbour");

        // Idle hold with address toggling
        cycle(0, 1, 1, 8'h33);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, i[0], (i[0] ? 8'h55 : 8'hAA), 1, 8'h33, "idle_hold");
        end
        cycle(0, 1, 1, 8'h55, 1, 8'h33, "idle_hold");
        cycle(0, 1, 1, 8'hAA, 1, 8'h55, "idle_mem_55");
        cycle(0, 0, 0, 8'h00, 1, 8'hAA, "idle_mem_aa");

        // Back-to-back reads, then write followed immediately by read
        cycle(0, 1, 1, 8'h01);
        cycle(0, 1, 1, 8'h02, 1, 8'h01, "b2b_01");
        cycle(0, 1, 1, 8'h03, 1, 8'h02, "b2b_02");
        cycle(0, 1, 0, 8'h04, 1, 8'h03, "b2b_03");
        cycle(0, 1, 1, 8'h04, 1, 8'h03, "b2b_wr_hold");
        cycle(0, 0, 0, 8'h00, 1, 8'h03, "b2b_wr_rd");

        // Reset in the middle: write 0x77 into 0x20, then reset aborts it
        cycle(0, 1, 1, 8'h77);
        cycle(0, 1, 0, 8'h20, 1, 8'h77, "mid_src");
        cycle(1, 1, 0, 8'h20);
        cycle(0, 1, 1, 8'h20, 1, 8'h00, "mid_data_zero");
        cycle(0, 0, 0, 8'h00, 1, 8'h20, "mid_identity");

        // Enable gating: neither read nor write happens with enable low
        cycle(0, 1, 1, 8'h10);
        cycle(0, 0, 1, 8'h44, 1, 8'h10, "gate_pre");
        cycle(0, 0, 0, 8'h44, 1, 8'h10, "gate_read");
        cycle(0, 1, 1, 8'h44, 1, 8'h10, "gate_write");
        cycle(0, 0, 0, 8'h00, 1, 8'h44, "gate_mem");

        // Randomized traffic over a narrow address set to force collisions
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, ra);
        end

        // Sweep all addresses so model and DUT contents are compared in full
        for (int i = 0; i < 256; i++) begin
            cycle(0, 1, 1, 8'(i));
        end
        cycle(0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_modport_mem
`default_nettype wire
